// File: rtl/game_round_ctrl.sv
// Round controller for a reaction/memory game: latches a challenge code, waits for a keypress,
// judges it and tracks score and lives. Optional answer timeout when ROUND_TIMEOUT_EN is defined.
module game_round_ctrl #(
  parameter int unsigned MAX_LIVES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] random,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       correct,
  output logic [3:0] eval_code,
  output logic       busy,
  output logic       result_valid,
  output logic       result_ok,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    JUDGE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t state;
  logic   expire_c;
  logic   judge_c;
  logic   verdict_c;

  // Only the low nibble of random is consumed; key_value is evaluated externally.
  logic   unused_bits;
  assign unused_bits = ^{random[7:4], key_value};

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign expire_c = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expire_c = 1'b0;
`endif

  // A keypress in the expiry cycle wins over the timeout.
  assign judge_c   = (state == WAIT) && (key_valid || expire_c);
  assign verdict_c = key_valid && correct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      eval_code    <= 4'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      score        <= 8'd0;
      lives        <= 2'd0;
      game_over    <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= LOAD;
            score     <= 8'd0;
            lives     <= 2'(MAX_LIVES);
            result_ok <= 1'b0;
            busy      <= 1'b1;
            game_over <= 1'b0;
          end
        end
        LOAD: begin
          state     <= WAIT;
          eval_code <= random[3:0];
`ifdef ROUND_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        WAIT: begin
          // Score/lives are settled on entry to JUDGE so they line up with the result pulse.
          if (judge_c) begin
            state        <= JUDGE;
            result_valid <= 1'b1;
            result_ok    <= verdict_c;
            if (verdict_c) begin
              if (score != 8'hFF) score <= score + 8'd1;
            end else begin
              lives <= lives - 2'd1;
            end
          end
`ifdef ROUND_TIMEOUT_EN
          else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        JUDGE: begin
          if (lives == 2'd0) begin
            state     <= OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed vector table, hand sequences and
// randomized traffic against a behavioural game model. Honours ROUND_TIMEOUT_EN.
module tb_game_round_ctrl;

  localparam int unsigned LIVES0 = 3;
  localparam int unsigned TO     = 8;
`ifdef ROUND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, key_valid = 1'b0, correct = 1'b0;
  logic [7:0] random = 8'd0;
  logic [3:0] key_value = 4'd0;
  logic [3:0] eval_code;
  logic       busy, result_valid, result_ok, game_over;
  logic [7:0] score;
  logic [1:0] lives;

  game_round_ctrl #(.MAX_LIVES(LIVES0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .random(random),
    .key_valid(key_valid), .key_value(key_value), .correct(correct),
    .eval_code(eval_code), .busy(busy), .result_valid(result_valid),
    .result_ok(result_ok), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d required %0d", name, idx, got, exp);
    end
  endtask

  // Behavioural model: the game as phases of a round, with plain integer score/lives.
  typedef enum int {P_IDLE, P_LOAD, P_WAIT, P_JUDGE, P_OVER} phase_t;
  phase_t m_phase = P_IDLE;
  int m_code = 0, m_score = 0, m_lives = 0, m_wait = 0;
  bit m_rv = 0, m_ok = 0;

  task automatic model_step(input bit r, input bit s, input int rnd, input bit kv, input bit c);
    m_rv = 0;
    if (r) begin
      m_phase = P_IDLE; m_code = 0; m_score = 0; m_lives = 0; m_ok = 0; m_wait = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_OVER: if (s) begin
          m_score = 0; m_lives = LIVES0; m_ok = 0; m_phase = P_LOAD;
        end
        P_LOAD: begin m_code = rnd % 16; m_wait = 0; m_phase = P_WAIT; end
        P_WAIT: begin
          m_wait++;
          if (kv || (TO_EN && m_wait == TO)) begin
            m_rv = 1;
            m_ok = kv && c;
            if (m_ok) m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
            else m_lives = m_lives - 1;
            m_phase = P_JUDGE;
          end
        end
        default: m_phase = (m_lives == 0) ? P_OVER : P_LOAD;
      endcase
    end
  endtask

  task automatic check_model(input string tag, input int idx);
    bit act;
    act = (m_phase == P_LOAD) || (m_phase == P_WAIT) || (m_phase == P_JUDGE);
    chk({tag, " busy"}, idx, int'(busy), int'(act));
    chk({tag, " result_valid"}, idx, int'(result_valid), int'(m_rv));
    chk({tag, " result_ok"}, idx, int'(result_ok), int'(m_ok));
    chk({tag, " score"}, idx, int'(score), m_score);
    chk({tag, " lives"}, idx, int'(lives), m_lives);
    chk({tag, " game_over"}, idx, int'(game_over), int'(m_phase == P_OVER));
    chk({tag, " eval_code"}, idx, int'(eval_code), m_code);
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge.
  task automatic tick(input bit r, input bit s, input logic [7:0] rnd, input bit kv,
                      input logic [3:0] kval, input bit c);
    reset = r; start = s; random = rnd; key_valid = kv; key_value = kval; correct = c;
    model_step(r, s, int'(rnd), kv, c);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, s; logic [7:0] rnd; bit kv; logic [3:0] kval; bit c;
    bit busy, rv, ok; int score, lives; bit go; int code;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, logic [7:0] rnd, bit kv, logic [3:0] kval, bit c,
                              bit b, bit rv, bit ok, int sc, int lv, bit go, int code);
    vec_t v;
    v.r = r; v.s = s; v.rnd = rnd; v.kv = kv; v.kval = kval; v.c = c;
    v.busy = b; v.rv = rv; v.ok = ok; v.score = sc; v.lives = lv; v.go = go; v.code = code;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    // Inputs during a cycle -> outputs expected just after the following edge.
    vecs[0]  = mk(1, 0, 8'h00, 0, 4'h0, 0,  0, 0, 0, 0, 0, 0, 0);  // reset
    vecs[1]  = mk(0, 1, 8'hA7, 0, 4'h0, 0,  1, 0, 0, 0, 3, 0, 0);  // start -> LOAD
    vecs[2]  = mk(0, 0, 8'hA7, 0, 4'h0, 0,  1, 0, 0, 0, 3, 0, 7);  // LOAD -> WAIT, code 7
    vecs[3]  = mk(0, 0, 8'h00, 0, 4'h0, 0,  1, 0, 0, 0, 3, 0, 7);  // still waiting
    vecs[4]  = mk(0, 0, 8'h00, 1, 4'h6, 1,  1, 1, 1, 1, 3, 0, 7);  // right answer
    vecs[5]  = mk(0, 1, 8'h3C, 0, 4'h0, 0,  1, 0, 1, 1, 3, 0, 7);  // start in JUDGE ignored
    vecs[6]  = mk(0, 0, 8'h3C, 0, 4'h0, 0,  1, 0, 1, 1, 3, 0, 12);
    vecs[7]  = mk(0, 0, 8'h00, 1, 4'h1, 0,  1, 1, 0, 1, 2, 0, 12); // wrong #1
    vecs[8]  = mk(0, 0, 8'h05, 0, 4'h0, 0,  1, 0, 0, 1, 2, 0, 12);
    vecs[9]  = mk(0, 0, 8'h05, 0, 4'h0, 0,  1, 0, 0, 1, 2, 0, 5);
    vecs[10] = mk(0, 0, 8'h00, 1, 4'h2, 0,  1, 1, 0, 1, 1, 0, 5);  // wrong #2
    vecs[11] = mk(0, 0, 8'hF9, 0, 4'h0, 0,  1, 0, 0, 1, 1, 0, 5);
    vecs[12] = mk(0, 0, 8'hF9, 0, 4'h0, 0,  1, 0, 0, 1, 1, 0, 9);
    vecs[13] = mk(0, 0, 8'h00, 1, 4'h3, 0,  1, 1, 0, 1, 0, 0, 9);  // wrong #3
    vecs[14] = mk(0, 0, 8'h00, 0, 4'h0, 0,  0, 0, 0, 1, 0, 1, 9);  // OVER
    vecs[15] = mk(0, 0, 8'h00, 1, 4'h8, 1,  0, 0, 0, 1, 0, 1, 9);  // key ignored in OVER
    vecs[16] = mk(0, 1, 8'h02, 0, 4'h0, 0,  1, 0, 0, 0, 3, 0, 9);  // restart
    vecs[17] = mk(0, 1, 8'h02, 1, 4'h4, 1,  1, 0, 0, 0, 3, 0, 2);  // start/key in LOAD ignored
    vecs[18] = mk(1, 0, 8'h00, 1, 4'h5, 1,  0, 0, 0, 0, 0, 0, 0);  // reset beats key in WAIT
    vecs[19] = mk(0, 0, 8'h00, 0, 4'h0, 0,  0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].r, vecs[i].s, vecs[i].rnd, vecs[i].kv, vecs[i].kval, vecs[i].c);
      chk("vec busy", i, int'(busy), int'(vecs[i].busy));
      chk("vec result_valid", i, int'(result_valid), int'(vecs[i].rv));
      chk("vec result_ok", i, int'(result_ok), int'(vecs[i].ok));
      chk("vec score", i, int'(score), vecs[i].score);
      chk("vec lives", i, int'(lives), vecs[i].lives);
      chk("vec game_over", i, int'(game_over), int'(vecs[i].go));
      chk("vec eval_code", i, int'(eval_code), vecs[i].code);
    end

    // Score saturation: keep answering correctly for more than 255 rounds.
    tick(1, 0, 8'h00, 0, 4'h0, 0);
    tick(0, 1, 8'h11, 0, 4'h0, 0);
    for (int i = 0; i < 3 * 258; i++) begin
      tick(0, 0, 8'($urandom), 1, 4'($urandom), 1);
      check_model("sat", i);
    end
    chk("sat score", 0, int'(score), 255);
    while (!result_valid && checks < 100000) tick(0, 0, 8'h00, 1, 4'h0, 1);
    chk("sat pulse", 0, int'(result_valid), 1);
    chk("sat result_ok", 0, int'(result_ok), 1);
    chk("sat score held", 0, int'(score), 255);

    // Long idle WAIT: with the timeout the round expires after TO cycles, otherwise it persists.
    tick(1, 0, 8'h00, 0, 4'h0, 0);
    tick(0, 1, 8'h4B, 0, 4'h0, 0);
    tick(0, 0, 8'h4B, 0, 4'h0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick(0, 0, 8'h00, 0, 4'h0, 0);
      chk("wait no pulse", i, int'(result_valid), 0);
    end
    tick(0, 0, 8'h00, 0, 4'h0, 0);
    chk("wait end pulse", 0, int'(result_valid), int'(TO_EN));
    chk("wait end lives", 0, int'(lives), TO_EN ? 2 : 3);
    check_model("wait", 0);
    if (!TO_EN) begin
      for (int i = 0; i < 20; i++) tick(0, 0, 8'h00, 0, 4'h0, 0);
      chk("wait persists busy", 0, int'(busy), 1);
      chk("wait persists pulse", 0, int'(result_valid), 0);
      tick(0, 0, 8'h00, 1, 4'h0, 1);
      chk("late key ok", 0, int'(result_ok), 1);
    end else begin
      tick(0, 0, 8'h00, 0, 4'h0, 0);
      tick(0, 0, 8'h77, 0, 4'h0, 0);
      for (int i = 0; i < int'(TO) - 1; i++) tick(0, 0, 8'h00, 0, 4'h0, 0);
      tick(0, 0, 8'h00, 1, 4'h7, 1);
      chk("expiry key pulse", 0, int'(result_valid), 1);
      chk("expiry key ok", 0, int'(result_ok), 1);
      chk("expiry key score", 0, int'(score), 1);
    end
    check_model("wait2", 0);

    // Randomized traffic against the model.
    tick(1, 0, 8'h00, 0, 4'h0, 0);
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 8'($urandom),
           ($urandom_range(0, 9) < 2), 4'($urandom), 1'($urandom));
      check_model("rand", i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
